// File: rtl/block_reg_wr_arbiter_if.sv
// Write-port bundle between requesters, the arbiter and block_reg.
interface block_reg_wr_arbiter_if #(
    parameter int NB_REQ        = 4,
    parameter int SIZE_ADDR_REG = 5,
    parameter int SIZE_REG      = 8
);
    localparam int GW = $clog2(NB_REQ);

    logic [NB_REQ-1:0]               req_valid;
    logic [NB_REQ-1:0]               req_lock;
    logic [NB_REQ*SIZE_ADDR_REG-1:0] req_addr;
    logic [NB_REQ*SIZE_REG-1:0]      req_data;
    logic [NB_REQ-1:0]               req_ready;
    logic                            write;
    logic [SIZE_ADDR_REG-1:0]        addrin;
    logic [SIZE_REG-1:0]             datain;
    logic [GW-1:0]                   grant_id;

    modport master (
        output req_valid, req_lock, req_addr, req_data,
        input  req_ready, write, addrin, datain, grant_id
    );

    modport slave (
        input  req_valid, req_lock, req_addr, req_data,
        output req_ready, write, addrin, datain, grant_id
    );
endinterface

// File: rtl/block_reg_wr_arbiter.sv
// Round-robin write-port arbiter with bounded locked bursts for block_reg.
// Optional BLOCK_REG_WR_ARB_R0_GUARD_EN: writes to register 0 are suppressed.
module block_reg_wr_arbiter #(
    parameter int NB_REQ        = 4,
    parameter int SIZE_ADDR_REG = 5,
    parameter int SIZE_REG      = 8,
    parameter int MAX_BURST     = 4
) (
    input  logic clk,
    input  logic reset,
    block_reg_wr_arbiter_if.slave bus
);
    localparam int PW = $clog2(NB_REQ);
    localparam int CW = $clog2(MAX_BURST + 1);
    localparam bit LOCK_EN = (MAX_BURST > 1);

    typedef enum logic {ARB, LOCKED} state_e;

    state_e                   state_q, state_d;
    logic [PW-1:0]            ptr_q, ptr_d;
    logic [PW-1:0]            own_q, own_d;
    logic [CW-1:0]            cnt_q, cnt_d;
    logic                     wr_q, wr_d;
    logic [SIZE_ADDR_REG-1:0] addr_q, addr_d;
    logic [SIZE_REG-1:0]      data_q, data_d;
    logic [PW-1:0]            gid_q, gid_d;

    logic [PW-1:0]            winner;
    logic                     found;
    logic [PW-1:0]            sel;
    logic [NB_REQ-1:0]        ready;
    logic                     acc;
    logic [SIZE_ADDR_REG-1:0] sel_addr;
    logic [SIZE_REG-1:0]      sel_data;

    // Descending scan so the smallest offset from ptr wins.
    always_comb begin
        int j;
        j      = 0;
        winner = '0;
        found  = 1'b0;
        for (int i = NB_REQ - 1; i >= 0; i--) begin
            j = int'(ptr_q) + i;
            if (j >= NB_REQ) j = j - NB_REQ;
            if (bus.req_valid[j]) begin
                winner = PW'(j);
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        ready = '0;
        if (reset) begin
            unique case (state_q)
                ARB:    if (found) ready[winner] = 1'b1;
                LOCKED: ready[own_q] = 1'b1;
            endcase
        end
    end

    assign sel      = (state_q == LOCKED) ? own_q : winner;
    assign acc      = |(bus.req_valid & ready);
    assign sel_addr = bus.req_addr[sel*SIZE_ADDR_REG +: SIZE_ADDR_REG];
    assign sel_data = bus.req_data[sel*SIZE_REG +: SIZE_REG];

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        own_d   = own_q;
        cnt_d   = cnt_q;
        wr_d    = 1'b0;
        addr_d  = addr_q;
        data_d  = data_q;
        gid_d   = gid_q;
        if (acc) begin
            unique case (state_q)
                ARB: begin
                    ptr_d = (winner == PW'(NB_REQ - 1)) ? '0
                                                        : winner + 1'b1;
                    own_d = winner;
                    cnt_d = CW'(1);
                    if (bus.req_lock[winner] && LOCK_EN)
                        state_d = LOCKED;
                end
                LOCKED: begin
                    cnt_d = cnt_q + 1'b1;
                    if (!bus.req_lock[own_q] || cnt_d == CW'(MAX_BURST))
                        state_d = ARB;
                end
            endcase
`ifdef BLOCK_REG_WR_ARB_R0_GUARD_EN
            if (sel_addr != '0) begin
                wr_d   = 1'b1;
                addr_d = sel_addr;
                data_d = sel_data;
                gid_d  = sel;
            end
`else
            wr_d   = 1'b1;
            addr_d = sel_addr;
            data_d = sel_data;
            gid_d  = sel;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ARB;
            ptr_q   <= '0;
            own_q   <= '0;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            gid_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            own_q   <= own_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            gid_q   <= gid_d;
        end
    end

    assign bus.req_ready = ready;
    assign bus.write     = wr_q;
    assign bus.addrin    = addr_q;
    assign bus.datain    = data_q;
    assign bus.grant_id  = gid_q;
endmodule

// File: doc/block_reg_wr_arbiter.md
# block_reg_wr_arbiter

Round-robin write-port arbiter and sequencer for the `block_reg` register file. It shares the single write port (`write`, `addrin`, `datain`) among `NB_REQ` requesters using a valid/ready handshake. It can lock the port for a bounded burst of consecutive writes from one requester. Its registered outputs drive `block_reg` directly, so the latch-enable path (`clk & write`) sees stable address and data for the whole cycle.

## Interface
- `NB_REQ`, 4: number of write requesters (2..16).
- `SIZE_ADDR_REG`, 5: register address width; must match `block_reg`.
- `SIZE_REG`, 8: register data width; must match `block_reg`.
- `MAX_BURST`, 4: maximum beats per locked burst (>=1; 1 disables locking).

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `req_valid`  in  NB_REQ  request i has a write pending.
- `req_lock`  in  NB_REQ  request i wants the port kept for its next beat.
- `req_addr`  in  NB_REQ*SIZE_ADDR_REG  target register per requester; slice i = bits [i*SIZE_ADDR_REG +: SIZE_ADDR_REG].
- `req_data`  in  NB_REQ*SIZE_REG  write data per requester; slice i = bits [i*SIZE_REG +: SIZE_REG].
- `req_ready`  out  NB_REQ  combinational; one-hot or zero; beat i is accepted on an edge where `req_valid[i] & req_ready[i]`.
- `write`  out  1  registered write strobe to `block_reg`.
- `addrin`  out  SIZE_ADDR_REG  registered write address.
- `datain`  out  SIZE_REG  registered write data.
- `grant_id`  out  clog2(NB_REQ)  registered index of the requester whose beat is currently on the port.

## Operation
- State: `ARB`, `LOCKED`, round-robin pointer `ptr`, burst owner `own`, beat counter `cnt` (width clog2(MAX_BURST+1)).
- ARB: winner = first i with `req_valid[i]`, searched cyclically from `ptr`. Assert `req_ready[winner]`; all other ready bits are 0.
- On acceptance in ARB: `ptr <= winner+1` (mod NB_REQ), `own <= winner`, `cnt <= 1`.
  - If `req_lock[winner]` and `MAX_BURST > 1`: go to LOCKED.
  - Otherwise: stay in ARB.
- LOCKED: `req_ready[own] = 1` and all others are 0, even if `own` is not valid. When `own` is not valid, a bubble occurs (`write=0`) and the state stays LOCKED.
- On acceptance in LOCKED: `cnt <= cnt+1`.
  - Return to ARB if the accepted beat has `req_lock=0` or `cnt+1 == MAX_BURST`.
  - `ptr` stays at `own+1`.
- Accepted beat: next cycle `write=1`, `addrin`/`datain` = accepted slice, `grant_id` = index.
- No acceptance: next cycle `write=0`; `addrin`, `datain` and `grant_id` hold their previous values.
- Requesters hold `req_valid`, `req_lock`, `req_addr` and `req_data` stable until accepted. Deasserting `req_valid` before acceptance is allowed and drops the request.
- Simultaneous requests to the same register from different requesters are written in grant order; the last written wins.
- While `reset` is low: all `req_ready` = 0; no beat is accepted.

## Timing
- Reset (edge with `reset=0`): `write=0`, `addrin=0`, `datain=0`, `grant_id=0`, `ptr=0`, `own=0`, `cnt=0`, state ARB. A burst in progress is abandoned.
- Latency: accepted at edge N, `write=1` during cycle N+1, and the register latch captures the value during the high phase of cycle N+1.
- Throughput: one write per cycle with back-to-back grants; no dead cycle between bursts or owners.
- `req_ready` depends only on registered state (state, `ptr`, `own`) and `req_valid`; there is no path from `req_lock`, `req_addr` or `req_data` to `req_ready`.
- All outputs to `block_reg` come straight from flops; there are no combinational glitches on `write`.

## Configuration
- `BLOCK_REG_WR_ARB_R0_GUARD_EN` defined: register 0 is hard-wired zero.
  - A beat with address 0 is accepted normally: ready, pointer and lock/burst accounting all proceed as usual.
  - The next cycle has `write=0`, and `addrin`/`datain`/`grant_id` hold their previous values.
- Undefined: address 0 is written like any other register.

## Test plan
- Reset: hold `reset=0` for 2 cycles with all `req_valid=1` -> `req_ready=0`, `write=0`, `addrin=0`, `datain=0`. Release -> requester 0 is granted first.
- Round-robin: all 4 valid continuously with lock=0 -> grant order 0,1,2,3,0, with `write=1` every cycle from the first grant+1.
- Burst: requester 2 valid with lock=1 for 6 beats, others valid, `MAX_BURST=4` -> beats 2,2,2,2, then 3,0,1,2. Data 0x11..0x14 is written in order to its addresses.
- Burst bubble and early end: requester 1 locks, drops valid for 2 cycles, then sends a lock=0 beat -> two `write=0` cycles, requester 3 stays unready, then ARB resumes at `ptr=2`.
- Reset mid-burst: `reset=0` during beat 2 of a locked burst -> next cycle `write=0`, state ARB, `ptr=0`. The following grant goes to the lowest valid index.
- R0 guard (macro defined): beat addr=0 data=0xAA -> `req_ready=1`, next cycle `write=0`. Repeat without the macro -> `write=1`, `addrin=0`, `datain=0xAA`.
